// File: rtl/input_fm_pkg.sv
// ============================================================================
// input_fm_pkg : shared constants and address helpers for the input_fm buffer
// Rev 1.0
// ============================================================================
`default_nettype none

package input_fm_pkg;

  localparam int NUM_BANKS = 4;

  // Default tile geometry used across the input_fm slice.
  localparam int AW_DEF = 16;
  localparam int TM_DEF = 16;
  localparam int TR_DEF = 64;
  localparam int TC_DEF = 16;
  localparam int K_DEF  = 3;

  localparam int CHUNK = TR_DEF * TC_DEF;
  localparam int OR    = TR_DEF - K_DEF + 1;
  localparam int OC    = TC_DEF - K_DEF + 1;

  // Counter width for a range of n values; a single-value range still needs one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int GRP_W = cnt_w(TM_DEF / NUM_BANKS);
  localparam int K_W   = cnt_w(K_DEF);
  localparam int OR_W  = cnt_w(OR);
  localparam int OC_W  = cnt_w(OC);

  // Each channel owns a contiguous Tr*Tc chunk; bits above the chunk field pick the bank.
  function automatic int bank_addr(input int ch, input int row, input int col,
                                   input int tr, input int tc);
    return ch * tr * tc + row * tc + col;
  endfunction

endpackage

`default_nettype wire

// File: rtl/input_fm_rd_sched_loop_cnt.sv
// ============================================================================
// loop_cnt : wrap counter with synchronous clear; wrap carries to the next loop
// Rev 1.0
// ============================================================================
`default_nettype none

module loop_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         inc,
  input  logic [W-1:0] max,
  output logic [W-1:0] value,
  output logic         wrap
);

  assign wrap = inc && (value == max);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (inc) begin
      value <= wrap ? '0 : value + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/input_fm_rd_sched.sv
// ============================================================================
// input_fm_rd_sched : walks a loaded tile in convolution order across 4 banks
// Rev 1.0
// ============================================================================
`default_nettype none

module input_fm_rd_sched
  import input_fm_pkg::*;
#(
  parameter int AW = 16,
  parameter int Tm = 16,
  parameter int Tr = 64,
  parameter int Tc = 16,
  parameter int K  = 3
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic                                  ready,
  output logic [AW-1:0]                         rd_addr0,
  output logic [AW-1:0]                         rd_addr1,
  output logic [AW-1:0]                         rd_addr2,
  output logic [AW-1:0]                         rd_addr3,
  output logic                                  addr_valid,
  output logic                                  data_valid,
  output logic [cnt_w(Tm/NUM_BANKS)-1:0]        grp,
  output logic [cnt_w(K)-1:0]                   kr,
  output logic [cnt_w(K)-1:0]                   kc,
  output logic [cnt_w(Tr-K+1)-1:0]              orow,
  output logic [cnt_w(Tc-K+1)-1:0]              ocol,
  output logic                                  first_acc,
  output logic                                  last_acc,
  output logic                                  busy,
  output logic                                  done
);

  localparam int GROUPS = Tm / NUM_BANKS;
  localparam int N_OR   = Tr - K + 1;
  localparam int N_OC   = Tc - K + 1;
  localparam int GW     = cnt_w(GROUPS);
  localparam int KW     = cnt_w(K);
  localparam int RW     = cnt_w(N_OR);
  localparam int CW     = cnt_w(N_OC);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_LAST = 2'd2} state_t;
  state_t state;

  logic [GW-1:0] cnt_g,  nx_g;
  logic [KW-1:0] cnt_kr, nx_kr, cnt_kc, nx_kc;
  logic [RW-1:0] cnt_or, nx_or;
  logic [CW-1:0] cnt_oc, nx_oc;
  logic          g_wrap, kr_wrap, kc_wrap, or_wrap, oc_wrap;
  logic          take, accept;
  logic [AW-1:0] addr_nx [NUM_BANKS];
  logic [AW-1:0] addr_q  [NUM_BANKS];

  assign take   = (state == S_IDLE) && start;
  assign accept = addr_valid && ready;

  // Innermost loop is ocol; each wrap carries outward in the same cycle.
  loop_cnt #(.W(CW)) u_oc (.clk(clk), .rst(rst), .clear(take), .inc(accept),
                           .max(CW'(N_OC - 1)), .value(cnt_oc), .wrap(oc_wrap));
  loop_cnt #(.W(RW)) u_or (.clk(clk), .rst(rst), .clear(take), .inc(oc_wrap),
                           .max(RW'(N_OR - 1)), .value(cnt_or), .wrap(or_wrap));
  loop_cnt #(.W(KW)) u_kc (.clk(clk), .rst(rst), .clear(take), .inc(or_wrap),
                           .max(KW'(K - 1)), .value(cnt_kc), .wrap(kc_wrap));
  loop_cnt #(.W(KW)) u_kr (.clk(clk), .rst(rst), .clear(take), .inc(kc_wrap),
                           .max(KW'(K - 1)), .value(cnt_kr), .wrap(kr_wrap));
  loop_cnt #(.W(GW)) u_g  (.clk(clk), .rst(rst), .clear(take), .inc(kr_wrap),
                           .max(GW'(GROUPS - 1)), .value(cnt_g), .wrap(g_wrap));

  // Next counter values feed the address adder so rd_addr* can be registered alongside the counters.
  always_comb begin
    nx_oc = (take || oc_wrap) ? '0 : (accept  ? cnt_oc + 1'b1 : cnt_oc);
    nx_or = (take || or_wrap) ? '0 : (oc_wrap ? cnt_or + 1'b1 : cnt_or);
    nx_kc = (take || kc_wrap) ? '0 : (or_wrap ? cnt_kc + 1'b1 : cnt_kc);
    nx_kr = (take || kr_wrap) ? '0 : (kc_wrap ? cnt_kr + 1'b1 : cnt_kr);
    nx_g  = (take || g_wrap)  ? '0 : (kr_wrap ? cnt_g  + 1'b1 : cnt_g);
  end

  for (genvar p = 0; p < NUM_BANKS; p++) begin : g_port
    always_comb begin
      addr_nx[p] = AW'(bank_addr(NUM_BANKS * int'(nx_g) + p,
                                 int'(nx_or) + int'(nx_kr),
                                 int'(nx_oc) + int'(nx_kc), Tr, Tc));
    end
  end

  assign rd_addr0 = addr_q[0];
  assign rd_addr1 = addr_q[1];
  assign rd_addr2 = addr_q[2];
  assign rd_addr3 = addr_q[3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      addr_valid <= 1'b0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      grp        <= '0;
      kr         <= '0;
      kc         <= '0;
      orow       <= '0;
      ocol       <= '0;
      first_acc  <= 1'b0;
      last_acc   <= 1'b0;
      for (int p = 0; p < NUM_BANKS; p++) addr_q[p] <= '0;
    end else begin
      data_valid <= accept;
      done       <= 1'b0;
      if (take || accept) begin
        for (int p = 0; p < NUM_BANKS; p++) addr_q[p] <= addr_nx[p];
      end
      // Index/flag copy lines up with the bank's one-cycle read latency.
      if (accept) begin
        grp       <= cnt_g;
        kr        <= cnt_kr;
        kc        <= cnt_kc;
        orow      <= cnt_or;
        ocol      <= cnt_oc;
        first_acc <= (cnt_g == '0) && (cnt_kr == '0) && (cnt_kc == '0);
        last_acc  <= (cnt_g == GW'(GROUPS - 1)) && (cnt_kr == KW'(K - 1)) &&
                     (cnt_kc == KW'(K - 1));
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_RUN;
            addr_valid <= 1'b1;
            busy       <= 1'b1;
          end
        end
        S_RUN: begin
          if (accept && g_wrap) begin
            state      <= S_LAST;
            addr_valid <= 1'b0;
            done       <= 1'b1;
          end
        end
        S_LAST: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_input_fm_rd_sched.sv
// ============================================================================
// tb_input_fm_rd_sched : vector table, loop-nest reference model, three tile configs
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_input_fm_rd_sched;
  import input_fm_pkg::*;

  localparam int AW = 16;
  localparam int A_TM = 4,  A_TR = 4,  A_TC = 4,  A_K = 3;
  localparam int B_TM = 8,  B_TR = 3,  B_TC = 3,  B_K = 3;
  localparam int D_TM = 16, D_TR = 64, D_TC = 16, D_K = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          start_s [3];
  logic          ready_s [3];
  logic [AW-1:0] ad [3][4];
  logic          av [3], dv [3], fa [3], la [3], bz [3], dn [3];

  logic [cnt_w(A_TM/4)-1:0] a_grp;  logic [cnt_w(A_K)-1:0] a_kr, a_kc;
  logic [cnt_w(A_TR-A_K+1)-1:0] a_or; logic [cnt_w(A_TC-A_K+1)-1:0] a_oc;
  logic [cnt_w(B_TM/4)-1:0] b_grp;  logic [cnt_w(B_K)-1:0] b_kr, b_kc;
  logic [cnt_w(B_TR-B_K+1)-1:0] b_or; logic [cnt_w(B_TC-B_K+1)-1:0] b_oc;
  logic [cnt_w(D_TM/4)-1:0] d_grp;  logic [cnt_w(D_K)-1:0] d_kr, d_kc;
  logic [cnt_w(D_TR-D_K+1)-1:0] d_or; logic [cnt_w(D_TC-D_K+1)-1:0] d_oc;

  input_fm_rd_sched #(.AW(AW), .Tm(A_TM), .Tr(A_TR), .Tc(A_TC), .K(A_K)) u_a (
    .clk(clk), .rst(rst), .start(start_s[0]), .ready(ready_s[0]),
    .rd_addr0(ad[0][0]), .rd_addr1(ad[0][1]), .rd_addr2(ad[0][2]), .rd_addr3(ad[0][3]),
    .addr_valid(av[0]), .data_valid(dv[0]), .grp(a_grp), .kr(a_kr), .kc(a_kc),
    .orow(a_or), .ocol(a_oc), .first_acc(fa[0]), .last_acc(la[0]), .busy(bz[0]), .done(dn[0]));

  input_fm_rd_sched #(.AW(AW), .Tm(B_TM), .Tr(B_TR), .Tc(B_TC), .K(B_K)) u_b (
    .clk(clk), .rst(rst), .start(start_s[1]), .ready(ready_s[1]),
    .rd_addr0(ad[1][0]), .rd_addr1(ad[1][1]), .rd_addr2(ad[1][2]), .rd_addr3(ad[1][3]),
    .addr_valid(av[1]), .data_valid(dv[1]), .grp(b_grp), .kr(b_kr), .kc(b_kc),
    .orow(b_or), .ocol(b_oc), .first_acc(fa[1]), .last_acc(la[1]), .busy(bz[1]), .done(dn[1]));

  input_fm_rd_sched #(.AW(AW), .Tm(D_TM), .Tr(D_TR), .Tc(D_TC), .K(D_K)) u_d (
    .clk(clk), .rst(rst), .start(start_s[2]), .ready(ready_s[2]),
    .rd_addr0(ad[2][0]), .rd_addr1(ad[2][1]), .rd_addr2(ad[2][2]), .rd_addr3(ad[2][3]),
    .addr_valid(av[2]), .data_valid(dv[2]), .grp(d_grp), .kr(d_kr), .kc(d_kc),
    .orow(d_or), .ocol(d_oc), .first_acc(fa[2]), .last_acc(la[2]), .busy(bz[2]), .done(dn[2]));

  typedef struct {
    int a0, a1, a2, a3;
    int grp, kr, kc, orow, ocol;
    int av, dv, fa, la, bz, dn;
  } obs_t;

  typedef struct {
    int a0, a1, a2, a3;
    int g, kr, kc, orow, ocol;
    int first, last;
  } beat_t;

  typedef struct {
    bit rdy;
    int a0;
    bit dv;
    bit first;
  } vec_t;

  beat_t exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic obs_t sample(input int id);
    obs_t o;
    o.a0 = int'(ad[id][0]); o.a1 = int'(ad[id][1]);
    o.a2 = int'(ad[id][2]); o.a3 = int'(ad[id][3]);
    o.av = int'(av[id]); o.dv = int'(dv[id]); o.fa = int'(fa[id]);
    o.la = int'(la[id]); o.bz = int'(bz[id]); o.dn = int'(dn[id]);
    case (id)
      0: begin o.grp = int'(a_grp); o.kr = int'(a_kr); o.kc = int'(a_kc);
               o.orow = int'(a_or); o.ocol = int'(a_oc); end
      1: begin o.grp = int'(b_grp); o.kr = int'(b_kr); o.kc = int'(b_kc);
               o.orow = int'(b_or); o.ocol = int'(b_oc); end
      default: begin o.grp = int'(d_grp); o.kr = int'(d_kr); o.kc = int'(d_kc);
               o.orow = int'(d_or); o.ocol = int'(d_oc); end
    endcase
    return o;
  endfunction

  // Reference: plain loop nest over the convolution order, address from channel/row/col.
  task automatic build_model(input int tm, input int tr, input int tc, input int k);
    beat_t b;
    exp_q.delete();
    for (int g = 0; g < tm / 4; g++)
      for (int r = 0; r < k; r++)
        for (int c = 0; c < k; c++)
          for (int y = 0; y < tr - k + 1; y++)
            for (int x = 0; x < tc - k + 1; x++) begin
              b.a0 = (4*g + 0) * tr * tc + (y + r) * tc + (x + c);
              b.a1 = (4*g + 1) * tr * tc + (y + r) * tc + (x + c);
              b.a2 = (4*g + 2) * tr * tc + (y + r) * tc + (x + c);
              b.a3 = (4*g + 3) * tr * tc + (y + r) * tc + (x + c);
              b.g = g; b.kr = r; b.kc = c; b.orow = y; b.ocol = x;
              b.first = (g == 0 && r == 0 && c == 0) ? 1 : 0;
              b.last  = (g == tm/4 - 1 && r == k - 1 && c == k - 1) ? 1 : 0;
              exp_q.push_back(b);
            end
  endtask

  task automatic check_zero(input obs_t o, input string tag);
    chk({tag, "_addr0"}, o.a0, 0); chk({tag, "_addr1"}, o.a1, 0);
    chk({tag, "_addr2"}, o.a2, 0); chk({tag, "_addr3"}, o.a3, 0);
    chk({tag, "_av"}, o.av, 0); chk({tag, "_dv"}, o.dv, 0);
    chk({tag, "_grp"}, o.grp, 0); chk({tag, "_kr"}, o.kr, 0); chk({tag, "_kc"}, o.kc, 0);
    chk({tag, "_orow"}, o.orow, 0); chk({tag, "_ocol"}, o.ocol, 0);
    chk({tag, "_first"}, o.fa, 0); chk({tag, "_last"}, o.la, 0);
    chk({tag, "_busy"}, o.bz, 0); chk({tag, "_done"}, o.dn, 0);
  endtask

  task automatic do_reset(input int id, input string tag);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin start_s[i] = 1'b0; ready_s[i] = 1'b0; end
    #1 check_zero(sample(id), {tag, "_async"});
    @(negedge clk);
    check_zero(sample(id), {tag, "_held"});
    rst = 1'b0;
  endtask

  // mode 0: ready=1, 1: ready toggles 1,0, 2: random ready. Starts injected mid-sweep and on done.
  task automatic run_sweep(input int id, input int mode, input string tag);
    obs_t o;
    int   n, ai, di, cyc, dones;
    bit   rdy, prev_acc;
    n = exp_q.size();
    ai = 0; di = 0; dones = 0; prev_acc = 1'b0;
    @(negedge clk);
    start_s[id] = 1'b1;
    ready_s[id] = 1'b1;
    @(negedge clk);
    start_s[id] = 1'b0;
    cyc = 1;
    while (dones == 0 && cyc < 4 * n + 50) begin
      o = sample(id);
      chk({tag, "_busy"}, o.bz, 1);
      chk({tag, "_dv_after_accept"}, o.dv, int'(prev_acc));
      if (o.dv != 0 && di < n) begin
        chk({tag, "_grp"}, o.grp, exp_q[di].g);
        chk({tag, "_kr"}, o.kr, exp_q[di].kr);
        chk({tag, "_kc"}, o.kc, exp_q[di].kc);
        chk({tag, "_orow"}, o.orow, exp_q[di].orow);
        chk({tag, "_ocol"}, o.ocol, exp_q[di].ocol);
        chk({tag, "_first"}, o.fa, exp_q[di].first);
        chk({tag, "_last"}, o.la, exp_q[di].last);
        chk({tag, "_done"}, o.dn, (di == n - 1) ? 1 : 0);
        if (mode == 0 && di == n - 1) chk({tag, "_done_latency"}, cyc, n + 1);
        if (id == 1 && (di == 8 || di == 9)) chk({tag, "_grp_step"}, o.grp, di - 8);
        di++;
      end else begin
        chk({tag, "_done_idle"}, o.dn, 0);
      end
      if (o.dn != 0) dones++;
      chk({tag, "_av"}, o.av, (ai < n) ? 1 : 0);
      if (o.av != 0 && ai < n) begin
        chk({tag, "_addr0"}, o.a0, exp_q[ai].a0);
        chk({tag, "_addr1"}, o.a1, exp_q[ai].a1);
        chk({tag, "_addr2"}, o.a2, exp_q[ai].a2);
        chk({tag, "_addr3"}, o.a3, exp_q[ai].a3);
        if (id == 1 && ai == 9) chk({tag, "_grp1_addr0"}, o.a0, 36);
        if (id == 2 && ai == n - 1) chk({tag, "_final_addr3"}, o.a3, 16383);
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 1);
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase
      ready_s[id] = rdy;
      start_s[id] = (cyc == 5) || (o.dn != 0);
      prev_acc = (o.av != 0) && rdy;
      if (prev_acc) ai++;
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_done_seen"}, dones, 1);
    chk({tag, "_beats"}, di, n);
    start_s[id] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      o = sample(id);
      chk({tag, "_post_busy"}, o.bz, 0);
      chk({tag, "_post_av"}, o.av, 0);
      chk({tag, "_post_dv"}, o.dv, 0);
      chk({tag, "_post_done"}, o.dn, 0);
      @(negedge clk);
    end
  endtask

  initial begin
    vec_t tbl[11];
    obs_t o;
    int   cnt;

    // Start of the 4x4 K=3 sweep with a ready pattern; port0 runs 0,1,4,5,1,2,5,6.
    tbl[0]  = '{1'b1, 0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1, 1'b1, 1'b1};
    tbl[2]  = '{1'b1, 1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 4, 1'b1, 1'b1};
    tbl[4]  = '{1'b0, 5, 1'b1, 1'b1};
    tbl[5]  = '{1'b0, 5, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 5, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1, 1'b1, 1'b1};
    tbl[8]  = '{1'b1, 2, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 5, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 6, 1'b1, 1'b0};

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin start_s[i] = 1'b0; ready_s[i] = 1'b0; end
    repeat (2) @(negedge clk);
    check_zero(sample(0), "por_a");
    check_zero(sample(2), "por_d");
    rst = 1'b0;

    @(negedge clk);
    start_s[0] = 1'b1;
    ready_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    o = sample(0);
    chk("tbl_first_addr1", o.a1, 16);
    chk("tbl_first_addr2", o.a2, 32);
    chk("tbl_first_addr3", o.a3, 48);
    for (int i = 0; i < 11; i++) begin
      o = sample(0);
      chk($sformatf("tbl%0d_av", i), o.av, 1);
      chk($sformatf("tbl%0d_addr0", i), o.a0, tbl[i].a0);
      chk($sformatf("tbl%0d_dv", i), o.dv, int'(tbl[i].dv));
      if (tbl[i].dv) chk($sformatf("tbl%0d_first", i), o.fa, int'(tbl[i].first));
      ready_s[0] = tbl[i].rdy;
      @(negedge clk);
    end
    do_reset(0, "tbl_rst");

    build_model(A_TM, A_TR, A_TC, A_K);
    run_sweep(0, 0, "A_rdy1");
    run_sweep(0, 1, "A_toggle");

    // Reset in the middle of a sweep, then a fresh sweep from address 0.
    @(negedge clk);
    start_s[0] = 1'b1;
    ready_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40 && cnt < 10; i++) begin
      o = sample(0);
      if (o.dv != 0) cnt++;
      if (cnt < 10) @(negedge clk);
    end
    chk("rst_reach_beat10", cnt, 10);
    chk("rst_no_done_yet", o.dn, 0);
    do_reset(0, "mid_rst");
    run_sweep(0, 0, "A_post_rst");
    run_sweep(0, 2, "A_rand");

    build_model(B_TM, B_TR, B_TC, B_K);
    run_sweep(1, 2, "B_rand");
    run_sweep(1, 0, "B_rdy1");

    build_model(D_TM, D_TR, D_TC, D_K);
    chk("D_beat_model_vs_count", exp_q.size(), 31248);
    run_sweep(2, 0, "D_rdy1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/input_fm_rd_sched.md
# input_fm_rd_sched

Read-address scheduler for the 4-bank `input_fm` tile buffer.
- On a `start` pulse it walks one loaded tile in convolution order and drives all four bank read ports every accepted beat. Port k reads input channel 4g+k.
- It also produces the loop indices and accumulate flags that the downstream MAC array and weight buffer need.
- It sits between the tile-level controller (`start`/`done`) and the `input_fm` read ports and PE array (`ready`/`data_valid`).

## Interface
- AW, 16: `input_fm` address width.
- Tm, 16: input channels per tile; must be a multiple of 4.
- Tr, 64: tile rows.
- Tc, 16: tile cols.
- K, 3: square kernel size, stride 1; requires K ≤ Tr and K ≤ Tc.
- Requirement on parameters: Tm·Tr·Tc ≤ 2^AW.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request to sweep the tile; ignored while busy.
- ready  in  1  consumer can take one data beat on the next cycle.
- rd_addr0..rd_addr3  out  AW each  bank read addresses, registered.
- addr_valid  out  1  rd_addr* hold a beat not yet accepted.
- data_valid  out  1  input_fm rd_data0..3 are valid this cycle.
- grp  out  clog2(Tm/4) or 1  channel group g of the data beat.
- kr, kc  out  clog2(K) or 1 each  kernel row/col of the data beat.
- orow  out  clog2(Tr-K+1) or 1  output row of the data beat.
- ocol  out  clog2(Tc-K+1) or 1  output col of the data beat.
- first_acc  out  1  data beat has g=kr=kc=0; the PE initialises its accumulator.
- last_acc  out  1  data beat is the final g/kr/kc combination for its output pixel.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse when the final beat is delivered.

## Operation
- Derived sizes:
  - OR = Tr-K+1, OC = Tc-K+1.
  - Loop order, outer to inner: g in [0,Tm/4), kr in [0,K), kc in [0,K), orow in [0,OR), ocol in [0,OC).
  - Beats per sweep: (Tm/4)·K²·OR·OC.
- Address of port k: (4g+k)·Tr·Tc + (orow+kr)·Tc + (ocol+kc).
  - Computed at AW width, no overflow given the parameter constraint.
  - Bits above the chunk field select the bank, consistent with the write path.
- A beat is accepted when addr_valid && ready. The counters advance only on accept; rd_addr* hold otherwise.
- FSM:
  - IDLE: busy=0. start → RUN, loads the counters with zero, addr_valid=1.
  - RUN: on accept of a non-final beat, advance the counters. On accept of the final beat, addr_valid=0 → LAST.
  - LAST: data_valid of the final beat is high, done=1 → IDLE.
- grp, kr, kc, orow, ocol, first_acc and last_acc are delayed copies of the address-stage values. They are aligned with data_valid.
- start while busy is ignored, and has no side effect.
- start in the same cycle as done → ignored; a new start is accepted from IDLE the next cycle.
- Reset, including mid-sweep:
  - State goes to IDLE.
  - All outputs go to 0: rd_addr*, addr_valid, data_valid, indices, flags, busy and done.
  - No partial done is emitted.

## Timing
- start sampled at edge t → addr_valid=1 and the first address from t+1. busy=1 from t+1 until the cycle done is high, inclusive.
- Bank read latency is 1 cycle. data_valid=1 in the cycle after each accept, exactly once per beat.
- With ready held high: one beat per cycle. The final data_valid, last_acc and done coincide N+1 cycles after start, where N is the beat count.
- ready low: addresses and counters frozen, no data_valid the following cycle. A frozen address keeps the bank output stable.
- Counter wrap: each counter returns to 0 when it reaches its maximum and carries to the next-outer counter, in the same cycle.

## Structure
- Package `input_fm_pkg`:
  - NUM_BANKS=4.
  - Derived localparams CHUNK=Tr·Tc, OR, OC, and the counter widths via $clog2.
  - The bank-address function.
  - Shared with `input_fm` and the load controller.
- One sub-module, `loop_cnt`: a parameterised wrap counter with inputs clear, inc and max, and outputs value and wrap. It is instantiated five times and chained through wrap.
- The address adder and the 1-cycle index/flag delay register stay in the top module.

## Test plan
- Tm=4, Tr=Tc=4, K=3, ready=1, one start:
  - 36 beats; done 37 cycles after start.
  - First port addresses 0/16/32/48.
  - Port0 sequence begins 0,1,4,5,1,2,5,6.
  - first_acc on beats 0–3; last_acc on beats 32–35.
- Same configuration, ready toggled 1,0 every cycle: 36 data_valid pulses, none in the cycle after a ready=0 cycle. The address sequence is identical to the ready=1 run.
- Default parameters, ready=1: 31248 beats. Final port3 address = 15·1024 + 63·16 + 15 = 16383; last_acc=1 on that beat.
- start pulsed again mid-sweep and again in the done cycle: both ignored, beat count unchanged, no second done.
- rst asserted at beat 10, then released and start issued: all outputs 0 during reset. The new sweep begins at address 0 with first_acc=1.
- Tm=8, Tr=Tc=3, K=3: OR=OC=1, 18 beats. grp goes 0→1 after beat 8; the first port0 address of group 1 is 36.
